// File: rtl/uart_rx_arbiter.sv
// Round-robin share of the receive-byte FIFO between port 0 (boot loader) and port 1 (core input
// instruction). One FIFO read per byte; 1 or WORD_BYTES bytes are assembled little-endian.
module uart_rx_arbiter #(
   parameter int WORD_BYTES = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   output logic                    o_buf_next,
   input  logic [7:0]              i_buf_dout,
   input  logic                    i_buf_dout_ready,
   input  logic [1:0]              i_req_valid,
   input  logic [1:0]              i_req_size,
   output logic [1:0]              o_req_ack,
   output logic [1:0]              o_rsp_valid,
   output logic [8*WORD_BYTES-1:0] o_rsp_data,
   output logic                    o_busy,
   output logic                    o_owner,
   output logic                    o_stray
);

   localparam int CW = $clog2(WORD_BYTES + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  r_state;
   logic                    r_grant;
   logic                    r_size;
   logic                    r_last_grant;
   logic [CW-1:0]           r_count;
   logic [8*WORD_BYTES-1:0] r_asm;
   logic [8*WORD_BYTES-1:0] r_rsp_data;
   logic                    r_buf_next;
   logic [1:0]              r_req_ack;
   logic [1:0]              r_rsp_valid;
   logic                    r_busy;
   logic                    r_owner;
   logic                    r_stray;

   logic                    w_any;
   logic                    w_grant;
   logic                    w_last_byte;
   logic [8*WORD_BYTES-1:0] w_asm_next;

   assign w_any = |i_req_valid;
   // With both ports valid the one that did not win last time is granted.
   assign w_grant     = (&i_req_valid) ? ~r_last_grant : ~i_req_valid[0];
   assign w_last_byte = r_size ? (r_count == LAST_IDX) : (r_count == '0);

   genvar gi;
   generate
      for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
         assign w_asm_next[8*gi +: 8] = (r_count == CW'(gi)) ? i_buf_dout : r_asm[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state      <= S_IDLE;
         r_grant      <= 1'b0;
         r_size       <= 1'b0;
         r_last_grant <= 1'b1;
         r_count      <= '0;
         r_asm        <= '0;
         r_rsp_data   <= '0;
         r_buf_next   <= 1'b0;
         r_req_ack    <= 2'b00;
         r_rsp_valid  <= 2'b00;
         r_busy       <= 1'b0;
         r_owner      <= 1'b0;
         r_stray      <= 1'b0;
      end else begin
         r_buf_next  <= 1'b0;
         r_req_ack   <= 2'b00;
         r_rsp_valid <= 2'b00;
         if (i_buf_dout_ready && (r_state != S_WAIT)) begin
            r_stray <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant      <= w_grant;
                  r_size       <= i_req_size[w_grant];
                  r_count      <= '0;
                  r_asm        <= '0;
                  r_owner      <= w_grant;
                  r_last_grant <= w_grant;
                  r_req_ack    <= w_grant ? 2'b10 : 2'b01;
                  r_buf_next   <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_buf_dout_ready) begin
                  r_asm   <= w_asm_next;
                  r_count <= r_count + CW'(1);
                  if (w_last_byte) begin
                     r_rsp_data  <= w_asm_next;
                     r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
                     r_state     <= S_DONE;
                  end else begin
                     r_buf_next <= 1'b1;
                     r_state    <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_buf_next  = r_buf_next;
   assign o_req_ack   = r_req_ack;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_busy      = r_busy;
   assign o_owner     = r_owner;
   assign o_stray     = r_stray;

   // A read request is a single cycle, so the FIFO never sees two reads in flight.
   a_next_single: assert property (@(posedge i_clk) disable iff (!i_rstn) o_buf_next |=> !o_buf_next);
   a_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn)
      $onehot0(o_req_ack) && $onehot0(o_rsp_valid));

endmodule
